// File: rtl/mult8_seq_ctrl.sv
// Sequential shift-and-add 8x8 unsigned multiplier sharing one adder8 CLA across 8 steps.
// Optional build macro: MULT8_ZERO_SKIP_EN (zero operand finishes in one cycle).

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gg0, pg0, gg1, pg1;

    assign g = a & b;
    assign p = a ^ b;

    // Two 4-bit lookahead groups; the group carry feeds the upper block directly.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        gg0  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg0  = &p[3:0];
        c[4] = gg0 | (pg0 & c[0]);
        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
        c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
        gg1  = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
        pg1  = &p[7:4];
        c[8] = gg1 | (pg1 & c[4]);
    end

    assign s    = p ^ c[7:0];
    assign cout = c[8];
endmodule

module mult8_seq_ctrl #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] P,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0] m;
    logic [W:0]   acc;
    logic [W-1:0] q;
    logic [3:0]   cnt;

    logic [W-1:0] addend;
    logic [W-1:0] sum;
    logic         cout;
    logic         load, step, finish;
`ifdef MULT8_ZERO_SKIP_EN
    logic         zskip;
`endif

    assign addend = q[0] ? m : '0;

    // acc[8] is always zero after the shift, so using it as carry-in leaves the sum unchanged.
    adder8 u_add (
        .a    (acc[W-1:0]),
        .b    (addend),
        .cin  (acc[W]),
        .s    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
`ifdef MULT8_ZERO_SKIP_EN
        zskip     = 1'b0;
`endif
        case (state)
            S_CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 4'd7) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_CALC;
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        // IDLE, DONE and any illegal encoding all accept a new request.
        if (state != S_CALC && start) begin
`ifdef MULT8_ZERO_SKIP_EN
            if (A == '0 || B == '0) begin
                zskip     = 1'b1;
                state_nxt = S_DONE;
            end else begin
                load      = 1'b1;
                state_nxt = S_CALC;
            end
`else
            load      = 1'b1;
            state_nxt = S_CALC;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            cnt <= '0;
            P   <= '0;
        end else begin
            if (load) begin
                m   <= A;
                acc <= '0;
                q   <= B;
                cnt <= '0;
            end else if (step) begin
                acc <= {1'b0, cout, sum[W-1:1]};
                q   <= {sum[0], q[W-1:1]};
                cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
            end
            // Product is taken from the final step's post-shift value.
            if (finish) P <= {cout, sum, q[W-1:1]};
`ifdef MULT8_ZERO_SKIP_EN
            if (zskip) P <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl: expected product and done cycle queued at issue, checked by a monitor.

module tb_mult8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  A, B;
    logic [15:0] P;
    logic        busy, done;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          cyc = 0;

    typedef struct {
        logic [15:0] p;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    mult8_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edges from the accepting edge until the cycle in which done is visible.
    function automatic int lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT8_ZERO_SKIP_EN
        if (a == 8'h00 || b == 8'h00) return 0;
`endif
        return 8;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input int gap);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(exp_t'{16'(a) * 16'(b), cyc + lat(a, b)});
        start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_done: none by cycle %0d (now %0d)", sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: P=%h at cycle %0d, expected no done", P, cyc);
                end else begin
                    e = sb.pop_front();
                    if (P !== e.p || cyc != e.due) begin
                        errors++;
                        $display("FAIL product: got P=%h at cycle %0d, expected %h at cycle %0d",
                                 P, cyc, e.p, e.due);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        check("reset_P", P, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-scale operands, with busy tracked through cycles 1-8.
        op(8'hFF, 8'hFF, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy_calc", {15'd0, busy}, 16'd1);
        end
        @(negedge clk);
        check("busy_in_done", {15'd0, busy}, 16'd0);
        repeat (2) @(negedge clk);

        op(8'h0D, 8'h0B, 11);
        op(8'h80, 8'h02, 11);
        op(8'h00, 8'h5A, 11);

        // start held with changing operands: only the first capture counts.
        A = 8'h21;
        B = 8'h47;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(exp_t'{16'h21 * 16'h47, cyc + 8});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            A = 8'($urandom);
            B = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during CALC cycle 4.
        op(8'hC3, 8'h7E, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_P", P, 16'h0000);
        check("midreset_busy", {15'd0, busy}, 16'd0);
        check("midreset_done", {15'd0, done}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(8'h03, 8'h05, 11);

        // start during DONE is accepted without a lost cycle.
        op(8'h0D, 8'h0B, 9);
        op(8'h12, 8'h34, 12);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 8'h00;
            if ($urandom_range(0, 15) == 0) rb = 8'h00;
            op(ra, rb, $urandom_range(9, 11));
        end

        repeat (12) @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
